// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-credit vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_t;

  localparam int DEF_PRICE    = 4;
  localparam int DEF_MAX_COIN = 2;

  // Ceiling log2, used to size coin and credit fields at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vending_credit_fsm.sv
// Coin-credit vending controller: accumulates coins, requests a vend at PRICE,
// then returns excess credit or a cancelled balance over the change handshake.
module vending_credit_fsm
  import vending_pkg::*;
#(
  parameter int PRICE    = DEF_PRICE,
  parameter int MAX_COIN = DEF_MAX_COIN,
  parameter int CNT_W    = 8,
  localparam int VAL_W    = clog2(MAX_COIN + 1),
  localparam int CREDIT_W = clog2(PRICE + MAX_COIN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_coin_valid,
  input  logic [VAL_W-1:0]    io_coin_value,
  output logic                io_coin_ready,
  input  logic                io_cancel,
  output logic                io_vend_valid,
  input  logic                io_vend_ready,
  output logic                io_change_valid,
  output logic [CREDIT_W-1:0] io_change_amount,
  input  logic                io_change_ready,
  output logic [CREDIT_W-1:0] io_credit,
  output logic                io_reject,
  output logic [CNT_W-1:0]    io_sales
);

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [VAL_W-1:0]    MAX_COIN_C = VAL_W'(MAX_COIN);

  vend_state_t         state_r, state_n;
  logic [CREDIT_W-1:0] credit_r, credit_n;
  logic [CNT_W-1:0]    sales_r, sales_n;
  logic                reject_r, reject_n;
  logic                vend_valid_r, change_valid_r;
  logic                coin_ready_s, accept_s;
  logic [CREDIT_W-1:0] sum_s, diff_s;

  assign coin_ready_s = ((state_r == IDLE) || (state_r == COLLECT)) && !io_cancel;
  assign accept_s     = io_coin_valid && coin_ready_s;
  assign sum_s        = credit_r + CREDIT_W'(io_coin_value);
  assign diff_s       = credit_r - PRICE_C;

  // Next-state, credit arithmetic, reject and sales counter update.
  always_comb begin
    state_n  = state_r;
    credit_n = credit_r;
    sales_n  = sales_r;
    reject_n = 1'b0;
    case (state_r)
      IDLE, COLLECT: begin
        if (io_cancel) begin
          // Cancel only refunds when there is credit to return.
          if (state_r == COLLECT) begin
            state_n = CHANGE;
          end else begin
            state_n = IDLE;
          end
        end else if (accept_s && (io_coin_value > MAX_COIN_C)) begin
          reject_n = 1'b1;
        end else if (accept_s && (io_coin_value != '0)) begin
          credit_n = sum_s;
          if (sum_s >= PRICE_C) begin
            state_n = VEND;
          end else begin
            state_n = COLLECT;
          end
        end else begin
          state_n = state_r;
        end
      end
      VEND: begin
        if (io_vend_ready) begin
          sales_n  = sales_r + CNT_W'(1'b1);
          credit_n = diff_s;
          if (diff_s != '0) begin
            state_n = CHANGE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = VEND;
        end
      end
      CHANGE: begin
        if (io_change_ready) begin
          credit_n = '0;
          state_n  = IDLE;
        end else begin
          state_n = CHANGE;
        end
      end
      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase
  end

  // State, credit, counters and handshake valids; valids follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      credit_r       <= '0;
      sales_r        <= '0;
      reject_r       <= 1'b0;
      vend_valid_r   <= 1'b0;
      change_valid_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      credit_r       <= credit_n;
      sales_r        <= sales_n;
      reject_r       <= reject_n;
      vend_valid_r   <= (state_n == VEND);
      change_valid_r <= (state_n == CHANGE);
    end
  end

  assign io_coin_ready    = coin_ready_s;
  assign io_vend_valid    = vend_valid_r;
  assign io_change_valid  = change_valid_r;
  assign io_change_amount = credit_r;
  assign io_credit        = credit_r;
  assign io_reject        = reject_r;
  assign io_sales         = sales_r;

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Directed bench for vending_credit_fsm: a vector table on a PRICE=4/MAX_COIN=2
// instance plus hand sequences on PRICE=7/MAX_COIN=5 and PRICE=4/MAX_COIN=5 instances.
module tb_vending_credit_fsm;

  logic clk;
  logic reset;

  // Instance A: PRICE=4, MAX_COIN=2, CNT_W=2 (VAL_W=2, CREDIT_W=3)
  logic       a_cv, a_can, a_vr, a_cr, a_rdy, a_vv, a_chv, a_rej;
  logic [1:0] a_val, a_sales;
  logic [2:0] a_amt, a_credit;

  // Instance B: PRICE=7, MAX_COIN=5 (VAL_W=3, CREDIT_W=4)
  logic       b_cv, b_can, b_vr, b_cr, b_rdy, b_vv, b_chv, b_rej;
  logic [2:0] b_val;
  logic [3:0] b_amt, b_credit;
  logic [7:0] b_sales;

  // Instance C: PRICE=4, MAX_COIN=5 (VAL_W=3, CREDIT_W=4)
  logic       c_cv, c_can, c_vr, c_cr, c_rdy, c_vv, c_chv, c_rej;
  logic [2:0] c_val;
  logic [3:0] c_amt, c_credit;
  logic [7:0] c_sales;

  int pass_cnt = 0;
  int total_cnt = 0;

  vending_credit_fsm #(.PRICE(4), .MAX_COIN(2), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset),
    .io_coin_valid(a_cv), .io_coin_value(a_val), .io_coin_ready(a_rdy),
    .io_cancel(a_can), .io_vend_valid(a_vv), .io_vend_ready(a_vr),
    .io_change_valid(a_chv), .io_change_amount(a_amt), .io_change_ready(a_cr),
    .io_credit(a_credit), .io_reject(a_rej), .io_sales(a_sales)
  );

  vending_credit_fsm #(.PRICE(7), .MAX_COIN(5), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset),
    .io_coin_valid(b_cv), .io_coin_value(b_val), .io_coin_ready(b_rdy),
    .io_cancel(b_can), .io_vend_valid(b_vv), .io_vend_ready(b_vr),
    .io_change_valid(b_chv), .io_change_amount(b_amt), .io_change_ready(b_cr),
    .io_credit(b_credit), .io_reject(b_rej), .io_sales(b_sales)
  );

  vending_credit_fsm #(.PRICE(4), .MAX_COIN(5), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset),
    .io_coin_valid(c_cv), .io_coin_value(c_val), .io_coin_ready(c_rdy),
    .io_cancel(c_can), .io_vend_valid(c_vv), .io_vend_ready(c_vr),
    .io_change_valid(c_chv), .io_change_amount(c_amt), .io_change_ready(c_cr),
    .io_credit(c_credit), .io_reject(c_rej), .io_sales(c_sales)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cv, val, can, vr, cr;
    int credit, vv, chv, amt, rdy, rej, sales;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_a(input string tag, input int credit, input int vv, input int chv,
                       input int amt, input int rdy, input int rej, input int sales);
    chk({tag, "_credit"}, int'(a_credit), credit);
    chk({tag, "_vend_valid"}, int'(a_vv), vv);
    chk({tag, "_change_valid"}, int'(a_chv), chv);
    chk({tag, "_change_amount"}, int'(a_amt), amt);
    chk({tag, "_coin_ready"}, int'(a_rdy), rdy);
    chk({tag, "_reject"}, int'(a_rej), rej);
    chk({tag, "_sales"}, int'(a_sales), sales);
  endtask

  initial begin
    reset = 1'b0;
    {a_cv, a_can, a_vr, a_cr} = 4'd0; a_val = 2'd0;
    {b_cv, b_can, b_vr, b_cr} = 4'd0; b_val = 3'd0;
    {c_cv, c_can, c_vr, c_cr} = 4'd0; c_val = 3'd0;

    // Row: inputs driven this cycle | outputs expected during this cycle
    //              cv val can vr cr | credit vv chv amt rdy rej sales
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 2, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 2, 0, 0, 0,   2, 0, 0, 2, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0,   4, 1, 0, 4, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 2, 0, 0, 0,   1, 0, 0, 1, 1, 0, 1});
    vecs.push_back('{1, 2, 0, 0, 0,   3, 0, 0, 3, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   5, 1, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   5, 1, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   5, 1, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 0,   5, 1, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 1,   1, 0, 1, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2});
    // cancel in IDLE is ignored but still blocks coins
    vecs.push_back('{0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2});
    // cancel beats a simultaneous coin in COLLECT: full refund of 1
    vecs.push_back('{1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2});
    vecs.push_back('{1, 2, 1, 0, 0,   1, 0, 0, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 1,   1, 0, 1, 1, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2});
    // two more vends wrap the 2-bit counter; cancel during VEND is ignored
    vecs.push_back('{1, 2, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2});
    vecs.push_back('{1, 2, 0, 0, 0,   2, 0, 0, 2, 1, 0, 2});
    vecs.push_back('{0, 0, 1, 1, 0,   4, 1, 0, 4, 0, 0, 2});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 3});
    vecs.push_back('{1, 2, 0, 0, 0,   0, 0, 0, 0, 1, 0, 3});
    vecs.push_back('{1, 2, 0, 0, 0,   2, 0, 0, 2, 1, 0, 3});
    vecs.push_back('{0, 0, 0, 1, 0,   4, 1, 0, 4, 0, 0, 3});
    // stray readies in IDLE do nothing
    vecs.push_back('{0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0});
    // illegal coin 3 > MAX_COIN 2: reject pulse, credit untouched
    vecs.push_back('{1, 3, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0});

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk_a("reset_hold", 0, 0, 0, 0, 1, 0, 0);
    chk("reset_hold_b_ready", int'(b_rdy), 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_cv  = 1'(vecs[i].cv);
      a_val = 2'(vecs[i].val);
      a_can = 1'(vecs[i].can);
      a_vr  = 1'(vecs[i].vr);
      a_cr  = 1'(vecs[i].cr);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].credit, vecs[i].vv, vecs[i].chv,
            vecs[i].amt, vecs[i].rdy, vecs[i].rej, vecs[i].sales);
    end
    @(negedge clk);
    {a_cv, a_can, a_vr, a_cr} = 4'd0; a_val = 2'd0;

    // B: coins 5 then 3 -> credit 8, vend, change 1
    @(negedge clk); b_cv = 1'b1; b_val = 3'd5;
    @(negedge clk); b_val = 3'd3; #1;
    chk("b_collect_credit", int'(b_credit), 5);
    @(negedge clk); b_cv = 1'b0; #1;
    chk("b_vend_credit", int'(b_credit), 8);
    chk("b_vend_valid", int'(b_vv), 1);
    b_vr = 1'b1;
    @(negedge clk); b_vr = 1'b0; #1;
    chk("b_vend_drop", int'(b_vv), 0);
    chk("b_change_valid", int'(b_chv), 1);
    chk("b_change_amount", int'(b_amt), 1);
    chk("b_sales", int'(b_sales), 1);
    b_cr = 1'b1;
    @(negedge clk); b_cr = 1'b0; #1;
    chk("b_idle_credit", int'(b_credit), 0);
    chk("b_idle_ready", int'(b_rdy), 1);
    chk("b_idle_change_valid", int'(b_chv), 0);

    // B: coin 3, then cancel together with coin 5 -> refund 3
    @(negedge clk); b_cv = 1'b1; b_val = 3'd3;
    @(negedge clk); b_val = 3'd5; b_can = 1'b1; #1;
    chk("b_cancel_ready", int'(b_rdy), 0);
    chk("b_cancel_credit", int'(b_credit), 3);
    @(negedge clk); b_cv = 1'b0; b_can = 1'b0; #1;
    chk("b_refund_valid", int'(b_chv), 1);
    chk("b_refund_amount", int'(b_amt), 3);
    @(negedge clk); #1;
    chk("b_refund_hold", int'(b_amt), 3);
    b_cr = 1'b1;
    @(negedge clk); b_cr = 1'b0; #1;
    chk("b_refund_done_credit", int'(b_credit), 0);
    chk("b_refund_done_valid", int'(b_chv), 0);
    chk("b_refund_sales", int'(b_sales), 1);

    // C: coin 1, illegal 7, then value 0
    @(negedge clk); c_cv = 1'b1; c_val = 3'd1;
    @(negedge clk); c_val = 3'd7; #1;
    chk("c_credit1", int'(c_credit), 1);
    chk("c_no_reject", int'(c_rej), 0);
    @(negedge clk); c_cv = 1'b0; #1;
    chk("c_reject_pulse", int'(c_rej), 1);
    chk("c_reject_credit", int'(c_credit), 1);
    @(negedge clk); #1;
    chk("c_reject_end", int'(c_rej), 0);
    c_cv = 1'b1; c_val = 3'd0;
    @(negedge clk); c_cv = 1'b0; #1;
    chk("c_zero_credit", int'(c_credit), 1);
    chk("c_zero_reject", int'(c_rej), 0);
    chk("c_zero_ready", int'(c_rdy), 1);

    // A: one vend, then async reset while the next vend is pending
    @(negedge clk); a_cv = 1'b1; a_val = 2'd2;
    @(negedge clk);
    @(negedge clk); a_cv = 1'b0; a_vr = 1'b1;
    @(negedge clk); a_vr = 1'b0; a_cv = 1'b1;
    @(negedge clk);
    @(negedge clk); a_cv = 1'b0; #1;
    chk_a("pre_reset", 4, 1, 0, 4, 0, 0, 1);
    #1 reset = 1'b0;
    #1;
    chk_a("async_reset", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk_a("after_reset", 0, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
